// File: rtl/eep_ctrl.sv
// EEPROM access controller: sequences single reads and charge-pump-timed writes
// with one shared down-counter; every pin-facing control output is registered.
module eep_ctrl #(
    parameter int unsigned CP_CYCLES = 1500000,
    parameter int unsigned RD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [1:0]  req_addr,
    input  logic [11:0] req_wdata,
    input  logic [11:0] eep_rd_data,
    output logic [1:0]  eep_addr,
    output logic        eep_cs_n,
    output logic        eep_r_w_n,
    output logic [11:0] eep_wdata,
    output logic        chrg_pmp_en,
    output logic [11:0] rd_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]  eep_addr_q;
    logic [11:0] eep_wdata_q;
    logic [11:0] rd_data_q;
    logic        cs_n_q;
    logic        r_w_n_q;
    logic        cp_en_q;
    logic        busy_q;
    logic        done_q;

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values of its peers, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            eep_addr_q  <= '0;
            eep_wdata_q <= '0;
            rd_data_q   <= '0;
            cs_n_q      <= 1'b1;
            r_w_n_q     <= 1'b1;
            cp_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The done cycle is a guard cycle: requests landing in it are dropped.
                    if (!done_q && wr_req) begin
                        state_q     <= WRITE;
                        cnt_q       <= CNT_W'(CP_CYCLES - 1);
                        eep_addr_q  <= req_addr;
                        eep_wdata_q <= req_wdata;
                        cs_n_q      <= 1'b0;
                        r_w_n_q     <= 1'b0;
                        cp_en_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (!done_q && rd_req) begin
                        state_q    <= READ;
                        cnt_q      <= CNT_W'(RD_CYCLES - 1);
                        eep_addr_q <= req_addr;
                        cs_n_q     <= 1'b0;
                        r_w_n_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                READ, WRITE: begin
                    if (cnt_q == '0) begin
                        if (state_q == READ) begin
                            rd_data_q <= eep_rd_data;
                        end
                        state_q <= IDLE;
                        cs_n_q  <= 1'b1;
                        r_w_n_q <= 1'b1;
                        cp_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    r_w_n_q <= 1'b1;
                    cp_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign eep_addr    = eep_addr_q;
    assign eep_wdata   = eep_wdata_q;
    assign rd_data     = rd_data_q;
    assign eep_cs_n    = cs_n_q;
    assign eep_r_w_n   = r_w_n_q;
    assign chrg_pmp_en = cp_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
